// File: rtl/mips_pkg.sv
// Constants and state encoding shared by the MIPS pipeline stages.
package mips_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IF_LOAD   = 2'd0,
    IF_RUN    = 2'd1,
    IF_HALTED = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Control, load-port and IF/ID output bundle of the instruction fetch stage.
interface instruction_fetch_unit_if #(
  parameter int LEN    = 32,
  parameter int ADDR_W = 11
);
  logic              in_start;
  logic              in_enable;
  logic              in_stall;
  logic              in_flush;
  logic              in_pc_src;
  logic [LEN-1:0]    in_pc_jump;
  logic              in_wr_en;
  logic [ADDR_W-1:0] in_wr_addr;
  logic [LEN-1:0]    in_wr_data;
  logic [LEN-1:0]    out_pc_jump;
  logic [LEN-1:0]    out_instruction;
  logic [LEN-1:0]    out_pc;
  logic              out_halted;
  logic [1:0]        out_state;

  modport master (
    output in_start, in_enable, in_stall, in_flush, in_pc_src, in_pc_jump,
           in_wr_en, in_wr_addr, in_wr_data,
    input  out_pc_jump, out_instruction, out_pc, out_halted, out_state
  );

  modport slave (
    input  in_start, in_enable, in_stall, in_flush, in_pc_src, in_pc_jump,
           in_wr_en, in_wr_addr, in_wr_data,
    output out_pc_jump, out_instruction, out_pc, out_halted, out_state
  );
endinterface

// File: rtl/instruction_fetch_unit_instr_mem.sv
// Word-addressed instruction store: combinational read, clocked write.
module instr_mem #(
  parameter int LEN       = 32,
  parameter int MEM_DEPTH = 2048,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LEN-1:0]    wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [LEN-1:0]    rd_data_o
);

  logic [LEN-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC, instruction memory and IF/ID register with load/run/halt control.
//   state     | meaning
//   IF_LOAD   | debug unit fills memory, PC parked at 0, IF/ID holds NOP
//   IF_RUN    | fetching; stall/flush/redirect/step applied each edge
//   IF_HALTED | HALT word fetched, PC frozen, leave only through reset
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int             LEN       = 32,
  parameter int             MEM_DEPTH = 2048,
  parameter int             ADDR_W    = $clog2(MEM_DEPTH),
  parameter logic [LEN-1:0] NOP_WORD  = LEN'(mips_pkg::NOP_WORD),
  parameter logic [LEN-1:0] HALT_WORD = LEN'(mips_pkg::HALT_WORD)
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.slave  bus
);

  if_state_e      state_q, state_d;
  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] instr_q, instr_d;
  logic [LEN-1:0] pc_jump_q, pc_jump_d;
  logic           halted_q, halted_d;

  logic [LEN-1:0] rd_data;
  logic [LEN-1:0] pc_plus1;
  logic           advance;
  logic           halt_hit;
  logic           mem_we;

  assign advance  = bus.in_enable & ~bus.in_stall;
  assign pc_plus1 = pc_q + LEN'(1);
  // A redirect or a squash on the same edge means the HALT is on a wrong path.
  assign halt_hit = (state_q == IF_RUN) & advance & ~bus.in_flush & ~bus.in_pc_src &
                    (rd_data == HALT_WORD);
  assign mem_we   = ~reset & bus.in_wr_en & (state_q == IF_LOAD);

  instr_mem #(
    .LEN       (LEN),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_instr_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .wr_addr_i (bus.in_wr_addr),
    .wr_data_i (bus.in_wr_data),
    .rd_addr_i (pc_q[ADDR_W-1:0]),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_jump_d = pc_jump_q;
    case (state_q)
      IF_LOAD: begin
        pc_d      = '0;
        instr_d   = NOP_WORD;
        pc_jump_d = '0;
        if (bus.in_start) state_d = IF_RUN;
      end
      IF_RUN: begin
        if (bus.in_pc_src)          pc_d = bus.in_pc_jump;
        else if (advance && !halt_hit) pc_d = pc_plus1;

        if (bus.in_flush) begin
          instr_d   = NOP_WORD;
          pc_jump_d = '0;
        end else if (advance) begin
          instr_d   = rd_data;
          pc_jump_d = pc_plus1;
        end

        if (halt_hit) state_d = IF_HALTED;
      end
      IF_HALTED: begin
        if (bus.in_enable) instr_d = NOP_WORD;
      end
      default: state_d = IF_LOAD;
    endcase
    halted_d = (state_d == IF_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IF_LOAD;
      pc_q      <= '0;
      instr_q   <= NOP_WORD;
      pc_jump_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_jump_q <= pc_jump_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.out_pc          = pc_q;
  assign bus.out_instruction = instr_q;
  assign bus.out_pc_jump     = pc_jump_q;
  assign bus.out_halted      = halted_q;
  assign bus.out_state       = state_q;

endmodule
